// File: rtl/bcd_digit_formatter_if.sv
// Value/decimal-point request channel into the BCD digit formatter.
// The master presents a value; the slave (formatter) signals readiness.
interface bcd_digit_formatter_if #(
  parameter int IN_W = 14
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_value;
  logic [3:0]      in_dp;

  modport master (output in_valid, output in_value, output in_dp, input in_ready);
  modport slave  (input in_valid, input in_value, input in_dp, output in_ready);
endinterface

// File: rtl/bcd_digit_formatter.sv
// Sequential double-dabble binary-to-BCD converter for a four-digit display.
// Digits, dp mask and ovf update together in a single LOAD cycle.
module bcd_digit_formatter #(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_digit_formatter_if.slave bus,
  output logic [3:0]           num3,
  output logic [3:0]           num2,
  output logic [3:0]           num1,
  output logic [3:0]           num0,
  output logic [3:0]           dpSelector,
  output logic                 ovf,
  output logic                 out_valid
);

  localparam int CW = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0] MAX_V = IN_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t          state;
  logic [IN_W-1:0] bin;
  logic [15:0]     bcd;
  logic [15:0]     corr;
  logic [CW-1:0]   cnt;
  logic [3:0]      dp_cap;
  logic            ovf_pend;

  assign bus.in_ready = (state == IDLE);

  // Add-3 correction on every nibble in parallel, no inter-nibble carry.
  always_comb begin
    corr = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        corr[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      dp_cap     <= '0;
      ovf_pend   <= 1'b0;
      num3       <= '0;
      num2       <= '0;
      num1       <= '0;
      num0       <= '0;
      dpSelector <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bin      <= bus.in_value;
            bcd      <= '0;
            dp_cap   <= bus.in_dp;
            ovf_pend <= (bus.in_value > MAX_V);
            cnt      <= CW'(IN_W);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {corr[14:0], bin[IN_W-1]};
          bin <= {bin[IN_W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= LOAD;
        end
        LOAD: begin
          if (ovf_pend) begin
            num3       <= 4'hE;
            num2       <= 4'hE;
            num1       <= 4'hE;
            num0       <= 4'hE;
            dpSelector <= '0;
          end else begin
            num3       <= bcd[15:12];
            num2       <= bcd[11:8];
            num1       <= bcd[7:4];
            num0       <= bcd[3:0];
            dpSelector <= dp_cap;
          end
          ovf       <= ovf_pend;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Directed bench for bcd_digit_formatter: vector table plus reset/drop sequences.
module tb_bcd_digit_formatter;

  localparam int IN_W = 14;
  localparam int LAT  = IN_W + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] num3, num2, num1, num0, dpSelector;
  logic       ovf, out_valid;

  int passes = 0;
  int total  = 0;

  bcd_digit_formatter_if #(.IN_W(IN_W)) bus ();

  bcd_digit_formatter #(.IN_W(IN_W), .MAX_VAL(9999)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .num3       (num3),
    .num2       (num2),
    .num1       (num1),
    .num0       (num0),
    .dpSelector (dpSelector),
    .ovf        (ovf),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         value;
    logic [3:0] dp;
    logic [3:0] e3, e2, e1, e0;
    logic [3:0] edp;
    logic       eovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " num3"}, num3, v.e3);
    check({tag, " num2"}, num2, v.e2);
    check({tag, " num1"}, num1, v.e1);
    check({tag, " num0"}, num0, v.e0);
    check({tag, " dp"}, dpSelector, v.edp);
    check({tag, " ovf"}, ovf, v.eovf);
  endtask

  // Present a value, wait for acceptance, then count edges until out_valid.
  task automatic start(input int value, input logic [3:0] dp);
    int n;
    bus.in_value = IN_W'(value);
    bus.in_dp    = dp;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("accept timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n;
    logic [15:0] held;
    logic stable;
    n = 0;
    stable = 1'b1;
    held = {num3, num2, num1, num0};
    check({tag, " out_valid low after accept"}, out_valid, 0);
    while (!out_valid && n < 40) begin
      if ({num3, num2, num1, num0} != held) stable = 1'b0;
      tick();
      n++;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " digits held during conversion"}, stable, 1);
    check({tag, " in_ready with out_valid"}, bus.in_ready, 1);
  endtask

  initial begin
    vec_t tmp;
    int n;
    int seen;
    //          value   dp       e3    e2    e1    e0    edp      eovf
    vecs[0] = '{1234,  4'b0100, 4'd1, 4'd2, 4'd3, 4'd4, 4'b0100, 1'b0};
    vecs[1] = '{9999,  4'b0001, 4'd9, 4'd9, 4'd9, 4'd9, 4'b0001, 1'b0};
    vecs[2] = '{10000, 4'b1010, 4'hE, 4'hE, 4'hE, 4'hE, 4'b0000, 1'b1};
    vecs[3] = '{0,     4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0};
    vecs[4] = '{7,     4'b1111, 4'd0, 4'd0, 4'd0, 4'd7, 4'b1111, 1'b0};
    vecs[5] = '{16383, 4'b0011, 4'hE, 4'hE, 4'hE, 4'hE, 4'b0000, 1'b1};
    vecs[6] = '{5678,  4'b0010, 4'd5, 4'd6, 4'd7, 4'd8, 4'b0010, 1'b0};
    vecs[7] = '{4090,  4'b1000, 4'd4, 4'd0, 4'd9, 4'd0, 4'b1000, 1'b0};

    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.in_dp    = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", out_valid, 0);
    tmp = '{0, 4'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0};
    check_outputs("reset", tmp);

    // Back-to-back: each new request is presented in the out_valid cycle.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d(%0d)", i, vecs[i].value);
      start(vecs[i].value, vecs[i].dp);
      wait_result(tag);
      check_outputs(tag, vecs[i]);
    end
    tick();
    check("out_valid single pulse", out_valid, 0);

    // Reset in the middle of a conversion, digits already at 1,2,3,4.
    start(1234, 4'b0100);
    wait_result("pre-reset");
    check_outputs("pre-reset", vecs[0]);
    start(5678, 4'b0010);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset in_ready", bus.in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    check_outputs("midreset", tmp);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("midreset no late out_valid", seen, 0);

    // A request pulsed while busy is dropped, not queued.
    start(8765, 4'b0000);
    tick();
    tick();
    bus.in_value = IN_W'(4321);
    bus.in_dp    = 4'b1111;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("drop latency", n, LAT - 3);
    tmp = '{8765, 4'b0, 4'd8, 4'd7, 4'd6, 4'd5, 4'b0000, 1'b0};
    check_outputs("drop", tmp);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("dropped request not queued", seen, 0);
    check_outputs("drop hold", tmp);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
